morse_keyer: RTL and testbench

- Parametrised successor to the ASCII-to-Morse lookup.
- Accepts ASCII characters over a valid/ready handshake and looks up each Morse pattern internally.
- Drives a timed on/off key line (dot, dash, inter-element, inter-character and word gaps), so an LED, buzzer or UART-to-tone path can be driven directly.
- Sits between the serial receive path and the output pin.

---
 rtl/morse_keyer.sv | 214 +++++++++++++++++++++
 tb/tb_morse_keyer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/morse_keyer.sv
// ASCII-to-Morse keyer: takes characters over valid/ready and drives a timed on/off key line.
// Element patterns are little-endian (bit0 sent first), 0 = dot, 1 = dash.
`timescale 1ns / 1ps
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES    = 1440000,
  parameter int unsigned DAH_UNITS      = 3,
  parameter int unsigned CHAR_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS = 7
) (
  input  logic       clk_24,
  input  logic       rst,
  input  logic [6:0] ascii_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
  output logic       bad_char
);

  localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CycLast  = CW'(UNIT_CYCLES - 1);
  localparam logic [3:0]    DahLoad  = 4'(DAH_UNITS - 1);
  localparam logic [3:0]    CharLoad = 4'(CHAR_GAP_UNITS - 1);
  // The preceding character already supplied its character gap.
  localparam logic [3:0]    WordLoad = 4'(WORD_GAP_UNITS - CHAR_GAP_UNITS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StMark, StSpace, StGap} state_e;

  state_e        state_q;
  logic [CW-1:0] cyc_q;
  logic [3:0]    unit_q;
  logic [2:0]    idx_q;
  logic [2:0]    len_q;
  logic [6:0]    pat_q;
  logic          space_q;
  logic          in_ready_q;
  logic          key_q;
  logic          bad_char_q;

  logic [6:0] upper;
  logic [9:0] lk_code;  // {len, elements with the first one at bit len-1}
  logic [6:0] lk_pat;
  logic       lk_space;
  logic       lk_bad;

  function automatic logic [6:0] reverse_elems(input logic [6:0] seq, input logic [2:0] len);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < int'(len)) r[3'(i)] = seq[3'(int'(len) - 1 - i)];
    end
    return r;
  endfunction

  always_comb begin
    upper = ascii_in;
    if (ascii_in >= 7'h61 && ascii_in <= 7'h7A) upper = ascii_in - 7'd32;
    lk_code = '0;
    case (upper)
      7'h21: lk_code = {3'd6, 7'b0101011};
      7'h22: lk_code = {3'd6, 7'b0010010};
      7'h24: lk_code = {3'd7, 7'b0001001};
      7'h26: lk_code = {3'd5, 7'b0001000};
      7'h27: lk_code = {3'd6, 7'b0011110};
      7'h28: lk_code = {3'd5, 7'b0010110};
      7'h29: lk_code = {3'd6, 7'b0101101};
      7'h2B: lk_code = {3'd5, 7'b0001010};
      7'h2C: lk_code = {3'd6, 7'b0110011};
      7'h2D: lk_code = {3'd6, 7'b0100001};
      7'h2E: lk_code = {3'd6, 7'b0010101};
      7'h2F: lk_code = {3'd5, 7'b0010010};
      7'h30: lk_code = {3'd5, 7'b0011111};
      7'h31: lk_code = {3'd5, 7'b0001111};
      7'h32: lk_code = {3'd5, 7'b0000111};
      7'h33: lk_code = {3'd5, 7'b0000011};
      7'h34: lk_code = {3'd5, 7'b0000001};
      7'h35: lk_code = {3'd5, 7'b0000000};
      7'h36: lk_code = {3'd5, 7'b0010000};
      7'h37: lk_code = {3'd5, 7'b0011000};
      7'h38: lk_code = {3'd5, 7'b0011100};
      7'h39: lk_code = {3'd5, 7'b0011110};
      7'h3A: lk_code = {3'd6, 7'b0111000};
      7'h3B: lk_code = {3'd6, 7'b0101010};
      7'h3D: lk_code = {3'd5, 7'b0010001};
      7'h3F: lk_code = {3'd6, 7'b0001100};
      7'h40: lk_code = {3'd6, 7'b0011010};
      7'h41: lk_code = {3'd2, 7'b0000001};
      7'h42: lk_code = {3'd4, 7'b0001000};
      7'h43: lk_code = {3'd4, 7'b0001010};
      7'h44: lk_code = {3'd3, 7'b0000100};
      7'h45: lk_code = {3'd1, 7'b0000000};
      7'h46: lk_code = {3'd4, 7'b0000010};
      7'h47: lk_code = {3'd3, 7'b0000110};
      7'h48: lk_code = {3'd4, 7'b0000000};
      7'h49: lk_code = {3'd2, 7'b0000000};
      7'h4A: lk_code = {3'd4, 7'b0000111};
      7'h4B: lk_code = {3'd3, 7'b0000101};
      7'h4C: lk_code = {3'd4, 7'b0000100};
      7'h4D: lk_code = {3'd2, 7'b0000011};
      7'h4E: lk_code = {3'd2, 7'b0000010};
      7'h4F: lk_code = {3'd3, 7'b0000111};
      7'h50: lk_code = {3'd4, 7'b0000110};
      7'h51: lk_code = {3'd4, 7'b0001101};
      7'h52: lk_code = {3'd3, 7'b0000010};
      7'h53: lk_code = {3'd3, 7'b0000000};
      7'h54: lk_code = {3'd1, 7'b0000001};
      7'h55: lk_code = {3'd3, 7'b0000001};
      7'h56: lk_code = {3'd4, 7'b0000001};
      7'h57: lk_code = {3'd3, 7'b0000011};
      7'h58: lk_code = {3'd4, 7'b0001001};
      7'h59: lk_code = {3'd4, 7'b0001011};
      7'h5A: lk_code = {3'd4, 7'b0001100};
      7'h5F: lk_code = {3'd6, 7'b0001101};
      default: lk_code = '0;
    endcase
    lk_pat   = reverse_elems(lk_code[6:0], lk_code[9:7]);
    lk_space = (ascii_in == 7'h20);
    lk_bad   = !lk_space && (lk_code[9:7] == 3'd0);
  end

  logic       unit_end;
  logic       last_el;
  logic [2:0] idx_nx;

  assign unit_end = (cyc_q == CycLast) && (unit_q == 4'd0);
  assign last_el  = (idx_q == len_q - 3'd1);
  assign idx_nx   = idx_q + 3'd1;

  always_ff @(posedge clk_24 or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      unit_q     <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      pat_q      <= '0;
      space_q    <= 1'b0;
      in_ready_q <= 1'b0;
      key_q      <= 1'b0;
      bad_char_q <= 1'b0;
    end else begin
      if (state_q == StMark || state_q == StSpace || state_q == StGap) begin
        if (cyc_q == CycLast) begin
          cyc_q <= '0;
          if (unit_q != 4'd0) unit_q <= unit_q - 4'd1;
        end else begin
          cyc_q <= cyc_q + 1'b1;
        end
      end
      case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            pat_q      <= lk_pat;
            len_q      <= lk_code[9:7];
            space_q    <= lk_space;
            bad_char_q <= lk_bad;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          bad_char_q <= 1'b0;
          cyc_q      <= '0;
          if (bad_char_q) begin
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end else if (space_q) begin
            unit_q  <= WordLoad;
            state_q <= StGap;
          end else begin
            idx_q   <= '0;
            unit_q  <= pat_q[0] ? DahLoad : 4'd0;
            key_q   <= 1'b1;
            state_q <= StMark;
          end
        end
        StMark: begin
          if (unit_end) begin
            key_q   <= 1'b0;
            unit_q  <= last_el ? CharLoad : 4'd0;
            state_q <= StSpace;
          end
        end
        StSpace: begin
          if (unit_end) begin
            if (last_el) begin
              in_ready_q <= 1'b1;
              state_q    <= StIdle;
            end else begin
              idx_q   <= idx_nx;
              unit_q  <= pat_q[idx_nx] ? DahLoad : 4'd0;
              key_q   <= 1'b1;
              state_q <= StMark;
            end
          end
        end
        StGap: begin
          if (unit_end) begin
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign key_out  = key_q;
  assign busy     = (state_q != StIdle);
  assign bad_char = bad_char_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with UNIT_CYCLES=4: checks key run lengths per character,
// handshake timing, invalid-character pulse and asynchronous reset mid-element.
`timescale 1ns / 1ps
module tb_morse_keyer;

  logic       clk_24 = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] ascii_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       key_out;
  logic       busy;
  logic       bad_char;

  int checks = 0;
  int failures = 0;
  int busy_drop = 0;
  int exp_q[$];

  morse_keyer #(
    .UNIT_CYCLES   (4),
    .DAH_UNITS     (3),
    .CHAR_GAP_UNITS(3),
    .WORD_GAP_UNITS(7)
  ) dut (
    .clk_24  (clk_24),
    .rst     (rst),
    .ascii_in(ascii_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .key_out (key_out),
    .busy    (busy),
    .bad_char(bad_char)
  );

  always #5 clk_24 = ~clk_24;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Counts consecutive negedge samples with key_out == v; a low run ends when the keyer idles.
  task automatic measure_run(input logic v, output int n);
    n = 0;
    while (key_out === v && !(v == 1'b0 && in_ready === 1'b1) && n < 200) begin
      n++;
      if (busy !== 1'b1) busy_drop++;
      @(negedge clk_24);
    end
  endtask

  // Called at a negedge; returns at the negedge of the LOAD cycle.
  task automatic send_char(input logic [6:0] c);
    int n;
    n = 0;
    ascii_in = c;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk_24);
    end
    if (n >= 100) check_eq("ready_timeout", 0, 1);
    @(negedge clk_24);
    in_valid = 1'b0;
    ascii_in = 7'h23;
  endtask

  task automatic check_char(input string tag, input logic first_v);
    int   n;
    logic v;
    check_eq({tag, "_load_key"}, int'(key_out), 0);
    check_eq({tag, "_load_busy"}, int'(busy), 1);
    check_eq({tag, "_load_ready"}, int'(in_ready), 0);
    check_eq({tag, "_load_bad"}, int'(bad_char), 0);
    busy_drop = 0;
    @(negedge clk_24);
    v = first_v;
    foreach (exp_q[i]) begin
      measure_run(v, n);
      check_eq($sformatf("%s_run%0d", tag, i), n, exp_q[i]);
      v = ~v;
    end
    check_eq({tag, "_end_ready"}, int'(in_ready), 1);
    check_eq({tag, "_end_busy"}, int'(busy), 0);
    check_eq({tag, "_busy_held"}, busy_drop, 0);
  endtask

  initial begin
    #2;
    check_eq("rst_key", int'(key_out), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_bad", int'(bad_char), 0);
    check_eq("rst_ready", int'(in_ready), 0);
    repeat (3) @(negedge clk_24);
    check_eq("rst_ready_clocked", int'(in_ready), 0);
    rst = 1'b1;
    #1;
    check_eq("release_ready_pre", int'(in_ready), 0);
    @(negedge clk_24);
    check_eq("release_ready", int'(in_ready), 1);
    check_eq("release_busy", int'(busy), 0);

    exp_q = '{4, 12};
    send_char(7'h45);
    check_char("E", 1'b1);

    exp_q = '{4, 4, 12, 12};
    send_char(7'h61);
    check_char("a_lower", 1'b1);
    send_char(7'h41);
    check_char("A", 1'b1);

    exp_q = '{12, 4, 12, 4, 12, 4, 12, 4, 12, 12};
    send_char(7'h30);
    check_char("zero", 1'b1);

    exp_q = '{4, 4, 4, 4, 12, 4, 12, 4, 4, 4, 4, 12};
    send_char(7'h3F);
    check_char("qmark", 1'b1);

    // Space handshakes in the first IDLE cycle after E.
    exp_q = '{4, 12};
    send_char(7'h45);
    check_char("E2", 1'b1);
    exp_q = '{16};
    send_char(7'h20);
    check_char("space", 1'b0);

    send_char(7'h23);
    check_eq("hash_bad_pulse", int'(bad_char), 1);
    check_eq("hash_key", int'(key_out), 0);
    check_eq("hash_ready_load", int'(in_ready), 0);
    @(negedge clk_24);
    check_eq("hash_bad_clear", int'(bad_char), 0);
    check_eq("hash_ready", int'(in_ready), 1);
    check_eq("hash_key_after", int'(key_out), 0);
    check_eq("hash_busy_after", int'(busy), 0);

    send_char(7'h54);
    @(negedge clk_24);
    @(negedge clk_24);
    check_eq("T_dash_key", int'(key_out), 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("T_abort_key", int'(key_out), 0);
    check_eq("T_abort_busy", int'(busy), 0);
    check_eq("T_abort_ready", int'(in_ready), 0);
    @(negedge clk_24);
    rst = 1'b1;
    #1;
    check_eq("T_release_ready_pre", int'(in_ready), 0);
    @(negedge clk_24);
    check_eq("T_release_ready", int'(in_ready), 1);
    check_eq("T_release_key", int'(key_out), 0);

    exp_q = '{12, 4, 4, 4, 12, 12};
    send_char(7'h4B);
    check_char("K", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
